// File: rtl/tl_tx_fc_gate.sv
// rtl/tl_tx_fc_gate.sv - transmit-side flow-control gate: admits TLPs only when partner credit allows
module tl_tx_fc_gate #(
    parameter int CREDIT_DEPTH = 12,
    parameter int DCRED_W      = 8
) (
    input  logic                    sclk,
    input  logic                    srst,
    input  logic [CREDIT_DEPTH-1:0] cl_p_h_i,
    input  logic [CREDIT_DEPTH-1:0] cl_p_d_i,
    input  logic [CREDIT_DEPTH-1:0] cl_np_h_i,
    input  logic [CREDIT_DEPTH-1:0] cl_cpl_h_i,
    input  logic [CREDIT_DEPTH-1:0] cl_cpl_d_i,
    input  logic                    cl_en_i,
    input  logic                    tlp_valid_i,
    input  logic [1:0]              tlp_type_i,
    input  logic [DCRED_W-1:0]      tlp_dcred_i,
    output logic                    tlp_ready_o,
    output logic [CREDIT_DEPTH-1:0] cc_p_h_o,
    output logic [CREDIT_DEPTH-1:0] cc_p_d_o,
    output logic [CREDIT_DEPTH-1:0] cc_np_h_o,
    output logic [CREDIT_DEPTH-1:0] cc_cpl_h_o,
    output logic [CREDIT_DEPTH-1:0] cc_cpl_d_o,
    output logic                    fc_init_done_o,
    output logic                    type_err_o
);

    localparam int N = CREDIT_DEPTH;
    localparam logic [N-1:0] HALF = N'(1) << (N - 1);
    localparam logic [N-1:0] ONE  = N'(1);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t state_q;

    logic [N-1:0] cl_p_h_q, cl_p_d_q, cl_np_h_q, cl_cpl_h_q, cl_cpl_d_q;
    logic [N-1:0] cc_p_h_q, cc_p_d_q, cc_np_h_q, cc_cpl_h_q, cc_cpl_d_q;
    logic [N-1:0] cc_p_h_d, cc_p_d_d, cc_np_h_d, cc_cpl_h_d, cc_cpl_d_d;
    logic         inf_p_h_q, inf_p_d_q, inf_np_h_q, inf_cpl_h_q, inf_cpl_d_q;
    logic         init_done_q;
    logic         type_err_q;

    logic [N-1:0] need_d;
    logic         is_p, is_np, is_cpl, is_rsvd;
    logic         ok_p_h, ok_p_d, ok_np_h, ok_cpl_h, ok_cpl_d;
    logic         credit_ok;
    logic         grant;

    // Modular check: the remaining window after this TLP must not have gone "negative".
    function automatic logic fld_pass(input logic inf, input logic [N-1:0] cl,
                                      input logic [N-1:0] cc, input logic [N-1:0] need);
        logic [N-1:0] diff;
        diff = cl - cc - need;
        return inf || (diff <= HALF);
    endfunction

    always_comb begin
        need_d   = N'(tlp_dcred_i);
        is_p     = (tlp_type_i == 2'd0);
        is_np    = (tlp_type_i == 2'd1);
        is_cpl   = (tlp_type_i == 2'd2);
        is_rsvd  = (tlp_type_i == 2'd3);

        ok_p_h   = fld_pass(inf_p_h_q,   cl_p_h_q,   cc_p_h_q,   ONE);
        ok_np_h  = fld_pass(inf_np_h_q,  cl_np_h_q,  cc_np_h_q,  ONE);
        ok_cpl_h = fld_pass(inf_cpl_h_q, cl_cpl_h_q, cc_cpl_h_q, ONE);
        ok_p_d   = (need_d == '0) || fld_pass(inf_p_d_q,   cl_p_d_q,   cc_p_d_q,   need_d);
        ok_cpl_d = (need_d == '0) || fld_pass(inf_cpl_d_q, cl_cpl_d_q, cc_cpl_d_q, need_d);

        credit_ok = (is_p   && ok_p_h   && ok_p_d)   ||
                    (is_np  && ok_np_h)              ||
                    (is_cpl && ok_cpl_h && ok_cpl_d);
    end

    assign grant       = !srst && (state_q == ST_ACTIVE) && tlp_valid_i && !is_rsvd && credit_ok;
    assign tlp_ready_o = grant;

    always_comb begin
        cc_p_h_d   = cc_p_h_q;
        cc_p_d_d   = cc_p_d_q;
        cc_np_h_d  = cc_np_h_q;
        cc_cpl_h_d = cc_cpl_h_q;
        cc_cpl_d_d = cc_cpl_d_q;
        if (grant) begin
            if (is_p) begin
                cc_p_h_d = cc_p_h_q + ONE;
                cc_p_d_d = cc_p_d_q + need_d;
            end
            if (is_np) begin
                cc_np_h_d = cc_np_h_q + ONE;
            end
            if (is_cpl) begin
                cc_cpl_h_d = cc_cpl_h_q + ONE;
                cc_cpl_d_d = cc_cpl_d_q + need_d;
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            state_q     <= ST_IDLE;
            cl_p_h_q    <= '0;
            cl_p_d_q    <= '0;
            cl_np_h_q   <= '0;
            cl_cpl_h_q  <= '0;
            cl_cpl_d_q  <= '0;
            cc_p_h_q    <= '0;
            cc_p_d_q    <= '0;
            cc_np_h_q   <= '0;
            cc_cpl_h_q  <= '0;
            cc_cpl_d_q  <= '0;
            inf_p_h_q   <= 1'b0;
            inf_p_d_q   <= 1'b0;
            inf_np_h_q  <= 1'b0;
            inf_cpl_h_q <= 1'b0;
            inf_cpl_d_q <= 1'b0;
            init_done_q <= 1'b0;
            type_err_q  <= 1'b0;
        end else begin
            cc_p_h_q   <= cc_p_h_d;
            cc_p_d_q   <= cc_p_d_d;
            cc_np_h_q  <= cc_np_h_d;
            cc_cpl_h_q <= cc_cpl_h_d;
            cc_cpl_d_q <= cc_cpl_d_d;
            if (tlp_valid_i && is_rsvd) begin
                type_err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cl_en_i) begin
                        // A zero limit on the very first advertisement means unlimited credit.
                        cl_p_h_q    <= cl_p_h_i;
                        cl_p_d_q    <= cl_p_d_i;
                        cl_np_h_q   <= cl_np_h_i;
                        cl_cpl_h_q  <= cl_cpl_h_i;
                        cl_cpl_d_q  <= cl_cpl_d_i;
                        inf_p_h_q   <= (cl_p_h_i   == '0);
                        inf_p_d_q   <= (cl_p_d_i   == '0);
                        inf_np_h_q  <= (cl_np_h_i  == '0);
                        inf_cpl_h_q <= (cl_cpl_h_i == '0);
                        inf_cpl_d_q <= (cl_cpl_d_i == '0);
                        init_done_q <= 1'b1;
                        state_q     <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (cl_en_i) begin
                        if (!inf_p_h_q)   cl_p_h_q   <= cl_p_h_i;
                        if (!inf_p_d_q)   cl_p_d_q   <= cl_p_d_i;
                        if (!inf_np_h_q)  cl_np_h_q  <= cl_np_h_i;
                        if (!inf_cpl_h_q) cl_cpl_h_q <= cl_cpl_h_i;
                        if (!inf_cpl_d_q) cl_cpl_d_q <= cl_cpl_d_i;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cc_p_h_o       = cc_p_h_q;
    assign cc_p_d_o       = cc_p_d_q;
    assign cc_np_h_o      = cc_np_h_q;
    assign cc_cpl_h_o     = cc_cpl_h_q;
    assign cc_cpl_d_o     = cc_cpl_d_q;
    assign fc_init_done_o = init_done_q;
    assign type_err_o     = type_err_q;

endmodule

// File: tb/tb_tl_tx_fc_gate.sv
// tb/tb_tl_tx_fc_gate.sv - self-checking bench for tl_tx_fc_gate
module tb_tl_tx_fc_gate;

    logic        sclk = 1'b0;
    logic        srst;
    logic [11:0] cl_p_h, cl_p_d, cl_np_h, cl_cpl_h, cl_cpl_d;
    logic        cl_en;
    logic        tlp_valid;
    logic [1:0]  tlp_type;
    logic [7:0]  tlp_dcred;
    logic        tlp_ready;
    logic [11:0] cc_p_h, cc_p_d, cc_np_h, cc_cpl_h, cc_cpl_d;
    logic        fc_init_done;
    logic        type_err;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // Model state, fields indexed 0=p_h 1=p_d 2=np_h 3=cpl_h 4=cpl_d
    int m_cl[5];
    int m_cc[5];
    bit m_inf[5];
    bit m_act;
    bit m_err;

    tl_tx_fc_gate #(.CREDIT_DEPTH(12), .DCRED_W(8)) dut (
        .sclk(sclk), .srst(srst),
        .cl_p_h_i(cl_p_h), .cl_p_d_i(cl_p_d), .cl_np_h_i(cl_np_h),
        .cl_cpl_h_i(cl_cpl_h), .cl_cpl_d_i(cl_cpl_d), .cl_en_i(cl_en),
        .tlp_valid_i(tlp_valid), .tlp_type_i(tlp_type), .tlp_dcred_i(tlp_dcred),
        .tlp_ready_o(tlp_ready),
        .cc_p_h_o(cc_p_h), .cc_p_d_o(cc_p_d), .cc_np_h_o(cc_np_h),
        .cc_cpl_h_o(cc_cpl_h), .cc_cpl_d_o(cc_cpl_d),
        .fc_init_done_o(fc_init_done), .type_err_o(type_err)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_ok(input int f, input int need);
        if (m_inf[f]) return 1;
        return ((((m_cl[f] - (m_cc[f] + need)) % 4096) + 4096) % 4096) <= 2048;
    endfunction

    function automatic bit m_ready();
        int dc;
        dc = int'(tlp_dcred);
        if (srst || !m_act || !tlp_valid) return 0;
        case (tlp_type)
            2'd0:    return m_ok(0, 1) && (dc == 0 || m_ok(1, dc));
            2'd1:    return m_ok(2, 1);
            2'd2:    return m_ok(3, 1) && (dc == 0 || m_ok(4, dc));
            default: return 0;
        endcase
    endfunction

    always @(posedge sclk) begin
        bit g;
        int lim[5];
        lim = '{int'(cl_p_h), int'(cl_p_d), int'(cl_np_h), int'(cl_cpl_h), int'(cl_cpl_d)};
        if (srst) begin
            for (int f = 0; f < 5; f++) begin
                m_cl[f] = 0; m_cc[f] = 0; m_inf[f] = 0;
            end
            m_act = 0;
            m_err = 0;
        end else begin
            g = m_ready();
            if (tlp_valid && tlp_type == 2'd3) m_err = 1;
            if (g) begin
                case (tlp_type)
                    2'd0: begin m_cc[0] = (m_cc[0] + 1) % 4096; m_cc[1] = (m_cc[1] + int'(tlp_dcred)) % 4096; end
                    2'd1: m_cc[2] = (m_cc[2] + 1) % 4096;
                    default: begin m_cc[3] = (m_cc[3] + 1) % 4096; m_cc[4] = (m_cc[4] + int'(tlp_dcred)) % 4096; end
                endcase
            end
            if (cl_en) begin
                for (int f = 0; f < 5; f++) begin
                    if (!m_act) m_inf[f] = (lim[f] == 0);
                    if (!m_act || !m_inf[f]) m_cl[f] = lim[f];
                end
                m_act = 1;
            end
        end
    end

    always @(negedge sclk) begin
        if (chk_en) begin
            chk("ready",     int'(tlp_ready),    int'(m_ready()));
            chk("cc_p_h",    int'(cc_p_h),       m_cc[0]);
            chk("cc_p_d",    int'(cc_p_d),       m_cc[1]);
            chk("cc_np_h",   int'(cc_np_h),      m_cc[2]);
            chk("cc_cpl_h",  int'(cc_cpl_h),     m_cc[3]);
            chk("cc_cpl_d",  int'(cc_cpl_d),     m_cc[4]);
            chk("init_done", int'(fc_init_done), int'(m_act));
            chk("type_err",  int'(type_err),     int'(m_err));
        end
    end

    task automatic nxt();
        @(posedge sclk);
        #1;
    endtask

    task automatic neg();
        @(negedge sclk);
    endtask

    task automatic set_cl(input int ph, input int pd, input int nph, input int ch, input int cd);
        cl_p_h = 12'(ph); cl_p_d = 12'(pd); cl_np_h = 12'(nph);
        cl_cpl_h = 12'(ch); cl_cpl_d = 12'(cd);
    endtask

    task automatic do_reset();
        srst = 1; tlp_valid = 0; cl_en = 0;
        neg(); nxt(); neg(); nxt();
        srst = 0;
    endtask

    task automatic do_init(input int ph, input int pd, input int nph, input int ch, input int cd);
        set_cl(ph, pd, nph, ch, cd);
        cl_en = 1;
        neg(); nxt();
        cl_en = 0;
    endtask

    task automatic send(input int ty, input int dc);
        tlp_valid = 1; tlp_type = 2'(ty); tlp_dcred = 8'(dc);
        neg(); nxt();
        tlp_valid = 0;
    endtask

    initial begin
        int g;
        srst = 1; cl_en = 0; tlp_valid = 1; tlp_type = 0; tlp_dcred = 2;
        set_cl(0, 0, 0, 0, 0);
        nxt();
        chk_en = 1;

        // Reset with a TLP pending, then first advertisement
        neg();
        chk("rst_ready", int'(tlp_ready), 0);
        chk("rst_cc_p_h", int'(cc_p_h), 0);
        chk("rst_init", int'(fc_init_done), 0);
        nxt();
        srst = 0; tlp_valid = 0;
        set_cl(4, 16, 8, 8, 8); cl_en = 1;
        neg();
        chk("init_pre", int'(fc_init_done), 0);
        nxt();
        cl_en = 0;
        neg();
        chk("init_post", int'(fc_init_done), 1);
        nxt();

        // Five posted TLPs against a header limit of four
        g = 0;
        tlp_valid = 1; tlp_type = 0; tlp_dcred = 2;
        for (int i = 0; i < 5; i++) begin
            neg(); if (tlp_ready) g++; nxt();
        end
        chk("p_grants", g, 4);
        neg();
        chk("p_cc_h4", int'(cc_p_h), 4);
        chk("p_cc_d8", int'(cc_p_d), 8);
        chk("p_stall", int'(tlp_ready), 0);
        nxt();
        set_cl(6, 16, 8, 8, 8); cl_en = 1;
        neg();
        chk("p_upd_same", int'(tlp_ready), 0);
        nxt();
        cl_en = 0;
        neg();
        chk("p_upd_next", int'(tlp_ready), 1);
        nxt();
        tlp_valid = 0;
        neg();
        chk("p_cc_h5", int'(cc_p_h), 5);
        chk("p_cc_d10", int'(cc_p_d), 10);
        nxt();

        // Non-posted: data field ignored, header limit 8
        g = 0;
        tlp_valid = 1; tlp_type = 1; tlp_dcred = 5;
        for (int i = 0; i < 9; i++) begin
            neg(); if (tlp_ready) g++; nxt();
        end
        tlp_valid = 0;
        chk("np_grants", g, 8);
        neg();
        chk("np_cc_h8", int'(cc_np_h), 8);
        nxt();

        // Infinite completion credit, 300 back-to-back grants
        do_reset();
        do_init(8, 8, 8, 0, 0);
        g = 0;
        tlp_valid = 1; tlp_type = 2; tlp_dcred = 16;
        for (int i = 0; i < 300; i++) begin
            neg(); if (tlp_ready) g++; nxt();
        end
        tlp_valid = 0;
        chk("cpl_grants", g, 300);
        neg();
        chk("cpl_cc_d704", int'(cc_cpl_d), 704);
        chk("cpl_cc_h300", int'(cc_cpl_h), 300);
        nxt();
        set_cl(8, 8, 8, 3, 3);
        cl_en = 1; neg(); nxt(); cl_en = 0;
        tlp_valid = 1; tlp_type = 2; tlp_dcred = 16;
        neg();
        chk("cpl_still_inf", int'(tlp_ready), 1);
        nxt();
        tlp_valid = 0;

        // Posted data counter driven up to 4090, then wrapped limit
        do_reset();
        do_init(0, 2000, 8, 8, 8);
        for (int k = 0; k < 16; k++) begin
            set_cl(0, 255 * (k + 1), 8, 8, 8);
            cl_en = 1; neg(); nxt(); cl_en = 0;
            send(0, 255);
        end
        set_cl(0, 4090, 8, 8, 8);
        cl_en = 1; neg(); nxt(); cl_en = 0;
        send(0, 10);
        neg();
        chk("wrap_cc_4090", int'(cc_p_d), 4090);
        nxt();
        set_cl(0, 4, 8, 8, 8);
        cl_en = 1; neg(); nxt(); cl_en = 0;
        tlp_valid = 1; tlp_type = 0; tlp_dcred = 6;
        neg();
        chk("wrap_grant", int'(tlp_ready), 1);
        nxt();
        tlp_valid = 0;
        neg();
        chk("wrap_cc_0", int'(cc_p_d), 0);
        nxt();

        // Limit raised in the same cycle a TLP waits
        do_reset();
        do_init(1, 100, 8, 8, 8);
        tlp_valid = 1; tlp_type = 0; tlp_dcred = 1;
        neg();
        chk("sc_first", int'(tlp_ready), 1);
        nxt();
        set_cl(2, 100, 8, 8, 8); cl_en = 1;
        neg();
        chk("sc_same", int'(tlp_ready), 0);
        nxt();
        cl_en = 0;
        neg();
        chk("sc_next", int'(tlp_ready), 1);
        nxt();
        tlp_valid = 0;

        // Reserved type
        tlp_valid = 1; tlp_type = 3; tlp_dcred = 0;
        neg();
        chk("rsvd_ready", int'(tlp_ready), 0);
        chk("rsvd_err_pre", int'(type_err), 0);
        nxt();
        tlp_valid = 0;
        neg();
        chk("rsvd_err_set", int'(type_err), 1);
        nxt();
        do_reset();
        neg();
        chk("rsvd_err_clr", int'(type_err), 0);
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tl_tx_fc_gate.md
Name: tl_tx_fc_gate

Overview:
- Transmit-side flow-control gate in the Transaction Layer.
- Sits upstream of the DLL write path. It admits a TLP from the TL transmit queue only when the link partner has advertised enough credit for it.
- Consumes the credit-limit (CL) outputs the DLL read path extracts from received InitFC/UpdateFC DLLPs.
- Maintains its own credits-consumed (CC) counters and applies the PCIe modular credit check per type.

Parameters:
- CREDIT_DEPTH, 12, width of every credit limit / consumed counter (N).
- DCRED_W, 8, width of the per-TLP data-credit request field (1 credit = 4 DW).

Ports:
- sclk  in  1  system clock
- srst  in  1  synchronous reset, active-high
- cl_p_h_i  in  CREDIT_DEPTH  advertised Posted header limit
- cl_p_d_i  in  CREDIT_DEPTH  advertised Posted data limit
- cl_np_h_i  in  CREDIT_DEPTH  advertised Non-Posted header limit
- cl_cpl_h_i  in  CREDIT_DEPTH  advertised Completion header limit
- cl_cpl_d_i  in  CREDIT_DEPTH  advertised Completion data limit
- cl_en_i  in  1  all cl_* inputs valid this cycle
- tlp_valid_i  in  1  TL queue has a TLP header pending
- tlp_type_i  in  2  0=P, 1=NP, 2=CPL, 3=reserved
- tlp_dcred_i  in  DCRED_W  data credits required (ignored for NP)
- tlp_ready_o  out  1  grant; TLP is consumed when tlp_valid_i & tlp_ready_o
- cc_p_h_o, cc_p_d_o, cc_np_h_o, cc_cpl_h_o, cc_cpl_d_o  out  CREDIT_DEPTH each  credits-consumed counters
- fc_init_done_o  out  1  first limits received; gate is active
- type_err_o  out  1  sticky; reserved type presented

Behaviour:
- Reset (srst=1 at a clock edge) applies to any state, including mid-operation:
  - All CC counters, CL registers and infinite flags clear to 0.
  - State returns to IDLE.
  - fc_init_done_o=0 and type_err_o=0; tlp_ready_o=0 combinationally.
- State machine:
  - IDLE: tlp_ready_o=0. On cl_en_i, latch all five limits and go to ACTIVE.
  - On that same first latch, set an infinite flag for each field whose value is 0.
  - ACTIVE: fc_init_done_o=1. Leaves ACTIVE only via srst.
- Limit updates in ACTIVE:
  - On cl_en_i, reload the CL register of each non-infinite field.
  - Infinite flags never change after the first latch.
- Credit check (combinational, from registered CL/CC only), for each required field:
  - need = 1 for a header.
  - need = tlp_dcred_i zero-extended for data.
  - The field passes if infinite, or if (CL - (CC + need)) mod 2^N <= 2^(N-1).
  - All arithmetic is N-bit wrap-around.
- Fields checked per type:
  - P: p_h and p_d.
  - NP: np_h only.
  - CPL: cpl_h and cpl_d.
  - tlp_dcred_i=0 always passes the data check.
- tlp_ready_o = ACTIVE & tlp_valid_i & (type != 3) & all required checks pass.
  - Purely combinational; zero-cycle grant latency.
- On grant, at the same edge:
  - The header CC of that type increments by 1.
  - The data CC increments by tlp_dcred_i (P/CPL only).
  - CC counters update even for infinite fields. They wrap mod 2^N.
- Back-to-back grants are allowed every cycle. Each check sees the CC value already updated by the previous cycle's grant.
- Grant and cl_en_i in the same cycle: the check uses the old CL. The new CL takes effect next cycle.
- Type 3 with tlp_valid_i: never granted; type_err_o is set (sticky until srst).
- A stalled TLP (ready=0) is held by the source; the gate keeps no state for it.

Test Plan:
- srst asserted for 2 cycles, tlp_valid_i=1 -> tlp_ready_o=0, all cc_*=0, fc_init_done_o=0. cl_en_i with p_h=4, p_d=16, others 8 -> fc_init_done_o=1 next cycle.
- After init, 5 consecutive P TLPs with dcred=2 -> 4 granted, cc_p_h_o=4, cc_p_d_o=8. Fifth stalls. cl_en_i with p_h=6 -> fifth granted the cycle after the update, cc_p_h_o=5.
- Init with cl_cpl_h=0, cl_cpl_d=0 (infinite) -> 300 CPL TLPs with dcred=16 all granted back-to-back. cc_cpl_d_o wraps to (300*16) mod 4096 = 704. Later cl_en_i with cpl fields=3 does not disable infinite.
- Wrap-around: CC forced near 4090 by prior grants, CL=4 (wrapped). P TLP needing 6 data credits -> granted, since (4-4096) mod 4096 = 4 <= 2048.
- Same-cycle cl_en_i raising p_h from CC-level to CC+1 while a P TLP is valid -> no grant that cycle, grant on the next.
- tlp_type_i=3 with valid -> tlp_ready_o=0 and type_err_o=1 from the next cycle. srst -> type_err_o=0.
